// File: rtl/wca_pkg.sv
// wca_pkg: shared types and helpers for the elementary cellular-automaton engine.
//   state_t     : engine control states (IDLE, RUN, DONE)
//   rule_lookup : returns rule[7-idx]. Row 000 sits in the rule MSB, so the
//                 hex value reads the same as the library's 0xNN rule names.
package wca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic rule_lookup(input logic [7:0] rule, input logic [2:0] idx);
    return rule[3'd7 - idx];
  endfunction

endpackage

// File: rtl/wca_cell.sv
// wca_cell: next-state logic for one automaton cell (purely combinational).
//   i_l    : left neighbour  (cell i+1)
//   i_c    : the cell itself (cell i)
//   i_r    : right neighbour (cell i-1)
//   i_rule : 8-bit truth-table rule
//   o_next : value of the cell in the next generation
module wca_cell
  import wca_pkg::*;
(
  input  logic       i_l,
  input  logic       i_c,
  input  logic       i_r,
  input  logic [7:0] i_rule,
  output logic       o_next
);

  // Neighbourhood {L,C,R} selects one row of the rule.
  assign o_next = rule_lookup(i_rule, {i_l, i_c, i_r});

endmodule

// File: rtl/wca_engine.sv
// wca_engine: runtime-programmable elementary cellular automaton that advances
// all N_CELLS cells by one generation per enabled clock for a requested number
// of steps.
//   i_clk       : rising-edge clock
//   i_rst_n     : synchronous active-low reset
//   i_rule_we   : load i_rule_in into the rule register (IDLE only)
//   i_rule_in   : truth-table rule, row 000 = bit 7 ... row 111 = bit 0
//   i_load      : load i_load_data into the cells, clears generation count (IDLE only)
//   i_load_data : new cell state, bit i = cell i
//   i_start     : begin a run of i_steps generations (IDLE only)
//   i_steps     : number of generations, sampled with i_start
//   i_hold      : freeze stepping while running
//   o_cells     : current cell state
//   o_rule      : current rule register
//   o_busy      : high while running
//   o_done      : one-cycle pulse after the last generation of a run
//   o_gen_count : generations applied since last load/reset (wraps)
module wca_engine #(
  parameter int          N_CELLS      = 16,
  parameter int          STEP_W       = 16,
  parameter logic        WRAP         = 1'b1,
  parameter logic        BOUNDARY_VAL = 1'b0,
  parameter logic [7:0]  RULE_INIT    = 8'hC7
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rule_we,
  input  logic [7:0]          i_rule_in,
  input  logic                i_load,
  input  logic [N_CELLS-1:0]  i_load_data,
  input  logic                i_start,
  input  logic [STEP_W-1:0]   i_steps,
  input  logic                i_hold,
  output logic [N_CELLS-1:0]  o_cells,
  output logic [7:0]          o_rule,
  output logic                o_busy,
  output logic                o_done,
  output logic [STEP_W-1:0]   o_gen_count
);

  import wca_pkg::*;

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  state_t              r_state;
  logic [N_CELLS-1:0]  r_cells;
  logic [7:0]          r_rule;
  logic [STEP_W-1:0]   r_gen;
  logic [STEP_W-1:0]   r_rem;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [N_CELLS-1:0]  w_cells_nxt;
  logic [7:0]          w_rule_nxt;
  logic [STEP_W-1:0]   w_gen_nxt;
  logic [STEP_W-1:0]   w_rem_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [N_CELLS-1:0]  w_gen_cells;

  // One rule cell per position; the end cells take their outer neighbour
  // from the opposite end (ring) or from the fixed boundary value.
  for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
    logic w_l;
    logic w_r;

    if (gi == N_CELLS - 1) begin : g_l_edge
      assign w_l = WRAP ? r_cells[0] : BOUNDARY_VAL;
    end else begin : g_l_in
      assign w_l = r_cells[gi + 1];
    end

    if (gi == 0) begin : g_r_edge
      assign w_r = WRAP ? r_cells[N_CELLS - 1] : BOUNDARY_VAL;
    end else begin : g_r_in
      assign w_r = r_cells[gi - 1];
    end

    wca_cell u_cell (
      .i_l    (w_l),
      .i_c    (r_cells[gi]),
      .i_r    (w_r),
      .i_rule (r_rule),
      .o_next (w_gen_cells[gi])
    );
  end

  // Next-state and next-output decode for the IDLE/RUN/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    w_cells_nxt = r_cells;
    w_rule_nxt  = r_rule;
    w_gen_nxt   = r_gen;
    w_rem_nxt   = r_rem;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // load/rule_we win over start; start is dropped in that cycle.
        if (i_load || i_rule_we) begin
          if (i_load) begin
            w_cells_nxt = i_load_data;
            w_gen_nxt   = '0;
          end else begin
            w_cells_nxt = r_cells;
          end
          if (i_rule_we) begin
            w_rule_nxt = i_rule_in;
          end else begin
            w_rule_nxt = r_rule;
          end
        end else if (i_start) begin
          if (i_steps == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_rem_nxt   = i_steps;
            w_busy_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RUN: begin
        w_busy_nxt = 1'b1;
        if (!i_hold) begin
          w_cells_nxt = w_gen_cells;
          w_gen_nxt   = r_gen + STEP_ONE;
          w_rem_nxt   = r_rem - STEP_ONE;
          if (r_rem == STEP_ONE) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cells <= '0;
      r_rule  <= RULE_INIT;
      r_gen   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cells <= w_cells_nxt;
      r_rule  <= w_rule_nxt;
      r_gen   <= w_gen_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_cells     = r_cells;
  assign o_rule      = r_rule;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_gen_count = r_gen;

endmodule

// File: tb/tb_wca_engine.sv
// tb_wca_engine: drives two 8-cell engines (ring and fixed-zero boundary) with
// the same stimulus, checks every cycle against a behavioural model, and pins
// the model with hand-computed literal expectations.
module tb_wca_engine;

  logic        clk = 1'b0;
  logic        rst_n, rule_we, load, start, hold;
  logic [7:0]  rule_in, load_data;
  logic [15:0] steps;

  logic [7:0]  cells_w, rule_w, cells_f, rule_f;
  logic        busy_w, done_w, busy_f, done_f;
  logic [15:0] gen_w, gen_f;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [7:0]  mw_cells, mf_cells, m_rule;
  logic [15:0] m_gen;
  int          m_rem;
  bit          m_done;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  wca_engine #(.N_CELLS(8), .STEP_W(16), .WRAP(1'b1), .BOUNDARY_VAL(1'b0), .RULE_INIT(8'hC7)) u_dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_rule_we(rule_we), .i_rule_in(rule_in),
    .i_load(load), .i_load_data(load_data), .i_start(start), .i_steps(steps),
    .i_hold(hold), .o_cells(cells_w), .o_rule(rule_w), .o_busy(busy_w),
    .o_done(done_w), .o_gen_count(gen_w)
  );

  wca_engine #(.N_CELLS(8), .STEP_W(16), .WRAP(1'b0), .BOUNDARY_VAL(1'b0), .RULE_INIT(8'hC7)) u_dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .i_rule_we(rule_we), .i_rule_in(rule_in),
    .i_load(load), .i_load_data(load_data), .i_start(start), .i_steps(steps),
    .i_hold(hold), .o_cells(cells_f), .o_rule(rule_f), .o_busy(busy_f),
    .o_done(done_f), .o_gen_count(gen_f)
  );

  // One generation computed straight from the rule definition.
  function automatic logic [7:0] m_step(input logic [7:0] c, input logic [7:0] rule,
                                        input bit wrap, input bit bval);
    logic [7:0] n;
    int l, r, idx;
    for (int i = 0; i < 8; i++) begin
      l   = (i == 7) ? (wrap ? int'(c[0]) : int'(bval)) : int'(c[i+1]);
      r   = (i == 0) ? (wrap ? int'(c[7]) : int'(bval)) : int'(c[i-1]);
      idx = l * 4 + int'(c[i]) * 2 + r;
      n[i] = ((int'(rule) >> (7 - idx)) & 1) == 1;
    end
    return n;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update at each active edge from the inputs sampled there.
  always @(posedge clk) begin
    if (!rst_n) begin
      mw_cells = 8'h00; mf_cells = 8'h00; m_rule = 8'hC7;
      m_gen = 16'h0; m_rem = 0; m_done = 1'b0; m_valid = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      if (!hold) begin
        mw_cells = m_step(mw_cells, m_rule, 1'b1, 1'b0);
        mf_cells = m_step(mf_cells, m_rule, 1'b0, 1'b0);
        m_gen    = m_gen + 16'd1;
        m_rem    = m_rem - 1;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else begin
      if (load || rule_we) begin
        if (load) begin
          mw_cells = load_data; mf_cells = load_data; m_gen = 16'h0;
        end
        if (rule_we) m_rule = rule_in;
      end else if (start) begin
        if (steps == 16'd0) m_done = 1'b1;
        else m_rem = int'(steps);
      end
    end
  end

  // Every-cycle comparison of both engines against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("cells_ring",  cells_w, mw_cells);
      cmp("cells_fixed", cells_f, mf_cells);
      cmp("rule_ring",   rule_w,  m_rule);
      cmp("rule_fixed",  rule_f,  m_rule);
      cmp("gen_ring",    gen_w,   m_gen);
      cmp("gen_fixed",   gen_f,   m_gen);
      cmp("busy_ring",   busy_w,  m_rem != 0);
      cmp("busy_fixed",  busy_f,  m_rem != 0);
      cmp("done_ring",   done_w,  m_done);
      cmp("done_fixed",  done_f,  m_done);
    end
  end

  task automatic idle_cmd(input bit ld, input logic [7:0] ld_data, input bit we, input logic [7:0] r);
    @(negedge clk);
    load = ld; load_data = ld_data; rule_we = we; rule_in = r;
    @(negedge clk);
    load = 1'b0; rule_we = 1'b0;
  endtask

  // Issue start, then watch until done (or abort) within a cycle budget.
  task automatic run(input logic [15:0] st, input int hold_at, input int hold_len,
                     input bit inject, input int abort_at,
                     output int cyc, output int busy_n, output int done_n);
    bit fin;
    fin = 1'b0; cyc = 0; busy_n = 0; done_n = 0;
    @(negedge clk);
    start = 1'b1; steps = st;
    for (int c = 1; c <= 100 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0; load = 1'b0; rule_we = 1'b0;
      hold = (c >= hold_at) && (c < hold_at + hold_len);
      if (inject && c == 2) begin
        load = 1'b1; load_data = 8'hFF; rule_we = 1'b1; rule_in = 8'h00;
        start = 1'b1; steps = 16'd9;
      end
      if (abort_at != 0 && c == abort_at) rst_n = 1'b0;
      if (abort_at != 0 && c == abort_at + 1) begin
        rst_n = 1'b1; cyc = c; fin = 1'b1;
      end else begin
        if (busy_w) busy_n++;
        if (done_w) begin
          done_n++; cyc = c; fin = 1'b1;
        end
      end
    end
    hold = 1'b0; start = 1'b0; load = 1'b0; rule_we = 1'b0;
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout: no done within 100 cycles, required done");
    end
  endtask

  initial begin
    int cyc, bn, dn, cyc_ref;
    logic [7:0] saved;
    rst_n = 1'b0; rule_we = 1'b0; load = 1'b0; start = 1'b0; hold = 1'b0;
    rule_in = 8'h00; load_data = 8'h00; steps = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp("reset_cells", cells_w, 8'h00);
    cmp("reset_rule",  rule_w,  8'hC7);
    cmp("reset_gen",   gen_w,   16'h0);
    cmp("reset_busy",  busy_w,  1'b0);
    cmp("reset_done",  done_w,  1'b0);

    // Rule 0xC7 on a single set cell
    idle_cmd(1'b1, 8'h10, 1'b1, 8'hC7);
    run(16'd1, 0, 0, 1'b0, 0, cyc, bn, dn);
    cmp("c7_ring",  cells_w, 8'hE7);
    cmp("c7_fixed", cells_f, 8'hE7);
    cmp("c7_gen",   gen_w,   16'd1);
    cmp("c7_done",  dn,      1);
    cmp("c7_lat",   cyc,     2);

    // Identity rule over five generations
    idle_cmd(1'b1, 8'hA5, 1'b1, 8'h33);
    run(16'd5, 0, 0, 1'b0, 0, cyc, bn, dn);
    cmp("id_cells", cells_w, 8'hA5);
    cmp("id_gen",   gen_w,   16'd5);
    cmp("id_busy",  bn,      5);
    cmp("id_done",  dn,      1);

    // Take-left rule: boundary behaviour
    idle_cmd(1'b1, 8'h01, 1'b1, 8'h0F);
    run(16'd1, 0, 0, 1'b0, 0, cyc, bn, dn);
    cmp("left_ring",  cells_w, 8'h80);
    cmp("left_fixed", cells_f, 8'h00);

    // Zero-step run
    idle_cmd(1'b1, 8'h3C, 1'b0, 8'h00);
    run(16'd0, 0, 0, 1'b0, 0, cyc, bn, dn);
    cmp("zero_lat",   cyc,     1);
    cmp("zero_busy",  bn,      0);
    cmp("zero_cells", cells_w, 8'h3C);
    cmp("zero_gen",   gen_w,   16'd0);

    // Hold delays completion but not the result; commands during RUN dropped
    idle_cmd(1'b1, 8'h10, 1'b1, 8'hC7);
    run(16'd4, 0, 0, 1'b0, 0, cyc_ref, bn, dn);
    saved = cells_w;
    idle_cmd(1'b1, 8'h10, 1'b0, 8'h00);
    run(16'd4, 2, 2, 1'b1, 0, cyc, bn, dn);
    cmp("hold_delay", cyc,     cyc_ref + 2);
    cmp("hold_cells", cells_w, saved);
    cmp("hold_rule",  rule_w,  8'hC7);
    cmp("hold_gen",   gen_w,   16'd4);

    // Reset during RUN after the second generation
    idle_cmd(1'b1, 8'h10, 1'b1, 8'h5A);
    run(16'd6, 0, 0, 1'b0, 3, cyc, bn, dn);
    cmp("abort_cells", cells_w, 8'h00);
    cmp("abort_rule",  rule_w,  8'hC7);
    cmp("abort_gen",   gen_w,   16'd0);
    cmp("abort_busy",  busy_w,  1'b0);
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      if (done_w) dn++;
      @(negedge clk);
    end
    cmp("abort_nodone", dn, 0);
    idle_cmd(1'b1, 8'h10, 1'b0, 8'h00);
    run(16'd1, 0, 0, 1'b0, 0, cyc, bn, dn);
    cmp("after_cells", cells_w, 8'hE7);
    cmp("after_done",  dn,      1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
